// File: rtl/dac_exp_pkg.sv
// Shared types and defaults for the DAC expansion driver.
package dac_exp_pkg;

  // Driver sequencing states
  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_WAKE = 2'd1,
    ST_RUN  = 2'd2,
    ST_STOP = 2'd3
  } dac_state_e;

  // CLK cycles the DAC is given to power up before conversions start
  localparam int unsigned WAKE_CYCLES_DEFAULT = 1024;

  // Mid-scale code driven whenever the stream is not running
  localparam logic [7:0] IDLE_CODE_DEFAULT = 8'h80;

endpackage

// File: rtl/dac_sample_fifo.sv
// Synchronous sample FIFO, DATA_WIDTH x 2**FIFO_AW, with flush.
// Push while full and pop while empty are ignored; flush wins over push.
module dac_sample_fifo
  import dac_exp_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_AW    = 4
) (
  input  logic                  CLK,
  input  logic                  RST_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty,
  output logic [FIFO_AW:0]      level
);

  localparam int DEPTH = 2 ** FIFO_AW;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [FIFO_AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]      level_q, level_d;
  logic                  do_push, do_pop;

  assign full  = (level_q == (FIFO_AW + 1)'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;
  assign dout  = mem_q[rd_ptr_q];

  // Next pointer/occupancy; pointers wrap naturally at DEPTH
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    do_push  = push && !full && !flush;
    do_pop   = pop && !empty && !flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   level_d = level_q + (FIFO_AW + 1)'(1);
        2'b01:   level_d = level_q - (FIFO_AW + 1)'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge CLK or negedge RST_n) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    if (!RST_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Sample storage write port
  // NOTE: storage has no reset; occupancy guards every read, so stale contents are never seen.
  always_ff @(posedge CLK) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/dac_expansion_driver.sv
// Drives an 8-bit parallel DAC: buffers a sample stream, divides CLK into
// DAC_CLK, sequences power-up/down and updates DAC_Dout on falling toggles
// so each code has a full half-period of setup before the latching edge.
module dac_expansion_driver
  import dac_exp_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    DIV_WIDTH   = 16,
  parameter int                    FIFO_AW     = 4,
  parameter int unsigned           WAKE_CYCLES = WAKE_CYCLES_DEFAULT,
  parameter logic [DATA_WIDTH-1:0] IDLE_CODE   = DATA_WIDTH'(IDLE_CODE_DEFAULT)
) (
  input  logic                  CLK,
  input  logic                  RST_n,
  input  logic                  enable,
  input  logic [DIV_WIDTH-1:0]  half_period,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  DAC_CLK,
  output logic                  DAC_PWR,
  output logic [DATA_WIDTH-1:0] DAC_Dout,
  output logic                  underflow,
  output logic [FIFO_AW:0]      fifo_level
);

  localparam int WAKE_W = $clog2(WAKE_CYCLES + 1);
  localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_CYCLES - 1);

  dac_state_e            state_q, state_d;
  logic [WAKE_W-1:0]     wake_cnt_q, wake_cnt_d;
  logic [DIV_WIDTH-1:0]  div_cnt_q, div_cnt_d;
  logic [DIV_WIDTH-1:0]  hp_q, hp_d;
  logic                  dac_clk_q, dac_clk_d;
  logic                  dac_pwr_q, dac_pwr_d;
  logic [DATA_WIDTH-1:0] dac_dout_q, dac_dout_d;
  logic                  underflow_q, underflow_d;

  logic [DIV_WIDTH-1:0]  hp_eff;
  logic                  toggle;
  logic                  fifo_push, fifo_pop, fifo_flush;
  logic                  fifo_full, fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_dout;

  assign s_ready    = !fifo_full && (state_q != ST_OFF);
  assign fifo_push  = s_valid && s_ready;

  assign DAC_CLK    = dac_clk_q;
  assign DAC_PWR    = dac_pwr_q;
  assign DAC_Dout   = dac_dout_q;
  assign underflow  = underflow_q;

  dac_sample_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_AW    (FIFO_AW)
  ) u_fifo (
    .CLK   (CLK),
    .RST_n (RST_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .din   (s_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Sequencing, clock division and sample presentation
  always_comb begin
    state_d     = state_q;
    wake_cnt_d  = '0;
    div_cnt_d   = div_cnt_q;
    hp_d        = hp_q;
    dac_clk_d   = dac_clk_q;
    dac_dout_d  = dac_dout_q;
    underflow_d = 1'b0;
    fifo_pop    = 1'b0;
    hp_eff      = (half_period == '0) ? DIV_WIDTH'(1) : half_period;
    toggle      = (div_cnt_q == hp_q - DIV_WIDTH'(1));

    unique case (state_q)
      ST_OFF: begin
        div_cnt_d  = '0;
        dac_clk_d  = 1'b0;
        dac_dout_d = IDLE_CODE;
        if (enable) state_d = ST_WAKE;
      end
      ST_WAKE: begin
        div_cnt_d = '0;
        dac_clk_d = 1'b0;
        hp_d      = hp_eff;
        if (!enable)                    state_d = ST_OFF;
        else if (wake_cnt_q == WAKE_LAST) state_d = ST_RUN;
        else                            wake_cnt_d = wake_cnt_q + WAKE_W'(1);
      end
      ST_RUN, ST_STOP: begin
        if (state_q == ST_RUN && !enable) state_d = ST_STOP;
        if (toggle) begin
          div_cnt_d = '0;
          dac_clk_d = !dac_clk_q;
          hp_d      = hp_eff;
          if (dac_clk_q) begin
            // Falling toggle: new code gets a whole low half-period of setup
            if (state_q == ST_STOP) begin
              dac_dout_d = IDLE_CODE;
              state_d    = ST_OFF;
            end else if (fifo_empty) begin
              underflow_d = 1'b1;
            end else begin
              fifo_pop   = 1'b1;
              dac_dout_d = fifo_dout;
            end
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_WIDTH'(1);
        end
      end
      default: state_d = ST_OFF;
    endcase

    // FIFO is emptied on every path into OFF and held empty there
    fifo_flush = (state_d == ST_OFF);
    // Power drops as WAKE is entered, and returns one cycle after OFF is reached
    dac_pwr_d  = (state_q == ST_OFF) && !enable;
  end

  // State and output registers
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q     <= ST_OFF;
      wake_cnt_q  <= '0;
      div_cnt_q   <= '0;
      hp_q        <= DIV_WIDTH'(1);
      dac_clk_q   <= 1'b0;
      dac_pwr_q   <= 1'b1;
      dac_dout_q  <= IDLE_CODE;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wake_cnt_q  <= wake_cnt_d;
      div_cnt_q   <= div_cnt_d;
      hp_q        <= hp_d;
      dac_clk_q   <= dac_clk_d;
      dac_pwr_q   <= dac_pwr_d;
      dac_dout_q  <= dac_dout_d;
      underflow_q <= underflow_d;
    end
  end

endmodule

// File: tb/tb_dac_expansion_driver.sv
// Self-checking bench for dac_expansion_driver: a behavioural model advanced
// every cycle plus directed timing/ordering checks with literal expectations.
module tb_dac_expansion_driver;

  localparam int WAKE_CYCLES = 1024;

  logic        CLK = 1'b0;
  logic        RST_n;
  logic        enable;
  logic [15:0] half_period;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic        DAC_CLK;
  logic        DAC_PWR;
  logic [7:0]  DAC_Dout;
  logic        underflow;
  logic [4:0]  fifo_level;

  int n_checks = 0;
  int n_fail   = 0;

  dac_expansion_driver #(
    .DATA_WIDTH  (8),
    .DIV_WIDTH   (16),
    .FIFO_AW     (4),
    .WAKE_CYCLES (WAKE_CYCLES),
    .IDLE_CODE   (8'h80)
  ) dut (
    .CLK         (CLK),
    .RST_n       (RST_n),
    .enable      (enable),
    .half_period (half_period),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .DAC_CLK     (DAC_CLK),
    .DAC_PWR     (DAC_PWR),
    .DAC_Dout    (DAC_Dout),
    .underflow   (underflow),
    .fifo_level  (fifo_level)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int M_OFF = 0, M_WAKE = 1, M_RUN = 2, M_STOP = 3;
  int         m_mode;
  int         m_wake_elapsed;
  int         m_elapsed;
  int         m_hp;
  bit         m_clk, m_pwr, m_uf;
  logic [7:0] m_dout;
  logic [7:0] m_q[$];

  function automatic bit m_ready();
    return (m_q.size() < 16) && (m_mode != M_OFF);
  endfunction

  function automatic int eff_hp(input logic [15:0] hp);
    return (hp == 16'd0) ? 1 : int'(hp);
  endfunction

  task automatic model_reset();
    m_mode = M_OFF; m_wake_elapsed = 0; m_elapsed = 0; m_hp = 1;
    m_clk = 1'b0; m_pwr = 1'b1; m_uf = 1'b0; m_dout = 8'h80;
    m_q.delete();
  endtask

  // Advance one CLK using the inputs the DUT will sample at the next rising edge
  task automatic model_step();
    bit do_push;
    int nxt;
    bit nxt_pwr;
    do_push = s_valid && m_ready();
    nxt     = m_mode;
    nxt_pwr = (m_mode == M_OFF) && !enable;
    m_uf    = 1'b0;
    case (m_mode)
      M_OFF: if (enable) begin nxt = M_WAKE; m_wake_elapsed = 0; end
      M_WAKE: begin
        if (!enable) nxt = M_OFF;
        else if (m_wake_elapsed == WAKE_CYCLES - 1) begin
          nxt = M_RUN; m_elapsed = 0; m_hp = eff_hp(half_period);
        end else m_wake_elapsed++;
      end
      default: begin
        if (m_mode == M_RUN && !enable) nxt = M_STOP;
        m_elapsed++;
        if (m_elapsed == m_hp) begin
          m_elapsed = 0;
          m_hp = eff_hp(half_period);
          if (!m_clk) m_clk = 1'b1;
          else begin
            m_clk = 1'b0;
            if (m_mode == M_STOP) begin m_dout = 8'h80; nxt = M_OFF; end
            else if (m_q.size() == 0) m_uf = 1'b1;
            else m_dout = m_q.pop_front();
          end
        end
      end
    endcase
    if (do_push) m_q.push_back(s_data);
    if (nxt == M_OFF) m_q.delete();
    m_mode = nxt;
    m_pwr  = nxt_pwr;
  endtask

  // Compare DUT against the model mid-cycle, then advance the model
  initial begin
    model_reset();
    forever begin
      @(negedge CLK);
      if (!RST_n) model_reset();
      check("m_pwr",       32'(DAC_PWR),    32'(m_pwr));
      check("m_dac_clk",   32'(DAC_CLK),    32'(m_clk));
      check("m_dout",      32'(DAC_Dout),   32'(m_dout));
      check("m_underflow", 32'(underflow),  32'(m_uf));
      check("m_s_ready",   32'(s_ready),    32'(m_ready()));
      check("m_level",     32'(fifo_level), 32'(m_q.size()));
      if (RST_n) model_step();
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input int n = 1);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Count CLK edges until DAC_CLK transitions to val (bounded)
  task automatic wait_clk(input logic val, input int budget, output int n);
    logic prev;
    bit   done;
    n = 0;
    done = 1'b0;
    while (!done) begin
      prev = DAC_CLK;
      tick();
      n++;
      if (prev != val && DAC_CLK == val) done = 1'b1;
      else if (n >= budget) begin
        n_checks++;
        n_fail++;
        $display("FAIL dac_clk_wait: no transition to %0b within %0d cycles", val, budget);
        done = 1'b1;
      end
    end
  endtask

  initial begin
    #600_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, k;
    RST_n = 1'b0; enable = 1'b0; half_period = 16'd3; s_data = 8'h00; s_valid = 1'b0;
    tick(3);
    check("rst_pwr",   32'(DAC_PWR),    32'd1);
    check("rst_clk",   32'(DAC_CLK),    32'd0);
    check("rst_dout",  32'(DAC_Dout),   32'h80);
    check("rst_ready", 32'(s_ready),    32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    RST_n = 1'b1;
    tick(3);
    check("off_pwr", 32'(DAC_PWR), 32'd1);

    // Wake, filling the FIFO with 0x00..0x0F meanwhile
    enable = 1'b1;
    tick();
    check("wake_pwr", 32'(DAC_PWR), 32'd0);
    k = 0;
    for (int i = 0; i < 16; i++) begin
      s_valid = 1'b1; s_data = 8'(i);
      tick(); k++;
    end
    s_valid = 1'b0;
    check("full_level", 32'(fifo_level), 32'd16);
    check("full_ready", 32'(s_ready),    32'd0);
    wait_clk(1'b1, 2000, n);
    k += n;
    check("first_rise_cycles", 32'(k), 32'(WAKE_CYCLES + 3));
    check("first_rise_idle",   32'(DAC_Dout), 32'h80);

    // Ordering: one sample per falling toggle, period 6 at hp=3
    for (int i = 0; i < 16; i++) begin
      wait_clk(1'b0, 50, n);
      check("order_gap",  32'(n), (i == 0) ? 32'd3 : 32'd6);
      check("order_data", 32'(DAC_Dout), 32'(i));
    end

    // Two more samples, then underflow holding the last one
    s_valid = 1'b1; s_data = 8'hA5; tick();
    s_data = 8'h5A; tick();
    s_valid = 1'b0;
    wait_clk(1'b0, 50, n);
    check("tail_a5", 32'(DAC_Dout), 32'hA5);
    wait_clk(1'b0, 50, n);
    check("tail_5a", 32'(DAC_Dout), 32'h5A);
    for (int i = 0; i < 2; i++) begin
      wait_clk(1'b0, 50, n);
      check("uf_pulse", 32'(underflow), 32'd1);
      check("uf_hold",  32'(DAC_Dout),  32'h5A);
    end

    // Push landing on the empty-pop edge is kept for the next toggle
    tick(5);
    s_valid = 1'b1; s_data = 8'h3C;
    tick();
    s_valid = 1'b0;
    check("coinc_fall",  32'(DAC_CLK),    32'd0);
    check("coinc_uf",    32'(underflow),  32'd1);
    check("coinc_hold",  32'(DAC_Dout),   32'h5A);
    check("coinc_level", 32'(fifo_level), 32'd1);
    wait_clk(1'b0, 50, n);
    check("coinc_gap",  32'(n),         32'd6);
    check("coinc_data", 32'(DAC_Dout),  32'h3C);
    check("coinc_nouf", 32'(underflow), 32'd0);

    // half_period = 0 behaves as 1
    half_period = 16'd0;
    wait_clk(1'b0, 50, n);
    wait_clk(1'b0, 50, n);
    wait_clk(1'b0, 50, n);
    check("hp0_period", 32'(n), 32'd2);

    // Back to 3, then 3 -> 5 during a high phase
    half_period = 16'd3;
    wait_clk(1'b0, 50, n);
    wait_clk(1'b0, 50, n);
    wait_clk(1'b0, 50, n);
    check("hp3_period", 32'(n), 32'd6);
    wait_clk(1'b1, 50, n);
    tick();
    half_period = 16'd5;
    wait_clk(1'b0, 50, n);
    check("hp_change_old_high", 32'(n), 32'd2);
    wait_clk(1'b1, 50, n);
    check("hp_change_new_low",  32'(n), 32'd5);
    wait_clk(1'b0, 50, n);
    check("hp_change_new_high", 32'(n), 32'd5);

    // Shutdown from the high phase at hp=4 with data still queued
    half_period = 16'd4;
    wait_clk(1'b0, 50, n);
    wait_clk(1'b0, 50, n);
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; s_data = 8'(8'h11 * (i + 1));
      tick();
    end
    s_valid = 1'b0;
    wait_clk(1'b1, 50, n);
    check("stop_pre_level", 32'(fifo_level), 32'd3);
    enable = 1'b0;
    wait_clk(1'b0, 50, n);
    check("stop_high_len", 32'(n),          32'd4);
    check("stop_idle",     32'(DAC_Dout),   32'h80);
    check("stop_flush",    32'(fifo_level), 32'd0);
    check("stop_pwr_low",  32'(DAC_PWR),    32'd0);
    tick();
    check("stop_pwr_high", 32'(DAC_PWR),    32'd1);

    // Second wake at hp=2, then asynchronous reset mid-RUN
    enable = 1'b1;
    half_period = 16'd2;
    wait_clk(1'b1, 2000, n);
    check("wake2_rise_cycles", 32'(n), 32'(1 + WAKE_CYCLES + 2));
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_data = 8'(8'hC0 + i);
      tick();
    end
    s_valid = 1'b0;
    tick(2);
    RST_n = 1'b0;
    #1;
    check("arst_pwr",   32'(DAC_PWR),    32'd1);
    check("arst_clk",   32'(DAC_CLK),    32'd0);
    check("arst_dout",  32'(DAC_Dout),   32'h80);
    check("arst_level", 32'(fifo_level), 32'd0);
    check("arst_ready", 32'(s_ready),    32'd0);
    enable = 1'b0;
    tick(2);
    RST_n = 1'b1;
    tick(3);
    check("post_rst_pwr", 32'(DAC_PWR), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
